// File: rtl/apb_ral_apb_mem_v2.sv
// APB3/APB4 completer: word-addressed RAM window plus a small register bank
// (CTRL, STATUS, INT_STAT, INT_EN, ERR_CNT) with wait states, strobes and PSLVERR.
module apb_ral_apb_mem_v2 #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 32,
   parameter int RAM_WORDS   = 1024,
   parameter int REG_BASE    = 'h1000,
   parameter int WAIT_STATES = 0,
   parameter int STA_W       = 8
) (
   input  logic                pclk,
   input  logic                presetn,
   input  logic                psel,
   input  logic                penable,
   input  logic                pwrite,
   input  logic [ADDR_W-1:0]   paddr,
   input  logic [DATA_W-1:0]   pwdata,
   input  logic [DATA_W/8-1:0] pstrb,
   output logic [DATA_W-1:0]   prdata,
   output logic                pready,
   output logic                pslverr,
   input  logic [STA_W-1:0]    sta_in,
   output logic                ctrl_ena,
   output logic [30:0]         ctrl_cfg,
   output logic                irq
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFS_W = $clog2(BYTES);
   localparam int IDX_W = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam logic [63:0] RAM_END = 64'(RAM_WORDS) * 64'(BYTES);

   localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(REG_BASE);
   localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(REG_BASE + 'h04);
   localparam logic [ADDR_W-1:0] A_ISTAT  = ADDR_W'(REG_BASE + 'h08);
   localparam logic [ADDR_W-1:0] A_IEN    = ADDR_W'(REG_BASE + 'h0C);
   localparam logic [ADDR_W-1:0] A_ECNT   = ADDR_W'(REG_BASE + 'h10);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK
   } state_t;

   state_t              state;
   logic [3:0]          wcnt;
   logic [DATA_W-1:0]   mem [RAM_WORDS];

   logic [31:0]         ctrl;
   logic [STA_W-1:0]    status;
   logic [STA_W-1:0]    int_stat;
   logic [STA_W-1:0]    int_en;
   logic [15:0]         err_cnt;

   logic                aligned;
   logic                in_ram;
   logic                hit_ram;
   logic                hit_ctrl;
   logic                hit_status;
   logic                hit_istat;
   logic                hit_ien;
   logic                hit_ecnt;
   logic                acc_err;
   logic [IDX_W-1:0]    ram_idx;
   logic [DATA_W-1:0]   rdata;
   logic [DATA_W-1:0]   wmask;
   logic [31:0]         m32;
   logic                wr_commit;
   logic                enter_ack;
   logic [STA_W-1:0]    istat_clr;

   // Address decode; the register bank sits above the RAM so the hits never overlap.
   assign aligned    = (paddr[OFS_W-1:0] == '0);
   assign in_ram     = (64'(paddr) < RAM_END);
   assign hit_ram    = aligned && in_ram;
   assign hit_ctrl   = aligned && (paddr == A_CTRL);
   assign hit_status = aligned && (paddr == A_STATUS);
   assign hit_istat  = aligned && (paddr == A_ISTAT);
   assign hit_ien    = aligned && (paddr == A_IEN);
   assign hit_ecnt   = aligned && (paddr == A_ECNT);
   assign acc_err    = !(hit_ram || hit_ctrl || hit_status || hit_istat || hit_ien || hit_ecnt);
   assign ram_idx    = IDX_W'(paddr >> OFS_W);

   always_comb begin
      rdata = '0;
      if (acc_err)
         rdata = DATA_W'(32'h0BADCAFE);
      else if (hit_ram)
         rdata = mem[ram_idx];
      else if (hit_ctrl)
         rdata = DATA_W'(ctrl);
      else if (hit_status)
         rdata = DATA_W'(status);
      else if (hit_istat)
         rdata = DATA_W'(int_stat);
      else if (hit_ien)
         rdata = DATA_W'(int_en);
      else if (hit_ecnt)
         rdata = DATA_W'(err_cnt);
   end

   always_comb begin
      wmask = '0;
      for (int i = 0; i < BYTES; i++)
         wmask[8*i +: 8] = {8{pstrb[i]}};
   end

   assign m32       = wmask[31:0];
   assign wr_commit = (state == ACK) && psel && penable && pwrite;
   assign istat_clr = (wr_commit && hit_istat) ? (pwdata[STA_W-1:0] & m32[STA_W-1:0]) : '0;

   // Read data and error are captured on the transition into ACK, so they are registered.
   assign enter_ack = ((state == IDLE) && psel && !penable && (WAIT_STATES == 0)) ||
                      ((state == WAIT) && psel && penable && (wcnt <= 4'd1));

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state   <= IDLE;
         wcnt    <= '0;
         prdata  <= '0;
         pready  <= 1'b0;
         pslverr <= 1'b0;
      end else begin
         pready  <= enter_ack;
         pslverr <= enter_ack && acc_err;
         prdata  <= enter_ack ? rdata : '0;
         case (state)
            IDLE: begin
               if (psel && !penable) begin
                  if (WAIT_STATES == 0) begin
                     state <= ACK;
                  end else begin
                     state <= WAIT;
                     wcnt  <= 4'(WAIT_STATES);
                  end
               end
            end
            WAIT: begin
               if (!psel)
                  state <= IDLE;
               else if (penable) begin
                  if (wcnt <= 4'd1)
                     state <= ACK;
                  else
                     wcnt <= wcnt - 4'd1;
               end
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // RAM contents deliberately survive reset.
   always_ff @(posedge pclk) begin
      if (wr_commit && hit_ram)
         mem[ram_idx] <= (mem[ram_idx] & ~wmask) | (pwdata & wmask);
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         ctrl     <= '0;
         status   <= '0;
         int_stat <= '0;
         int_en   <= '0;
         err_cnt  <= '0;
         irq      <= 1'b0;
      end else begin
         status   <= sta_in;
         // A rising STATUS bit sets INT_STAT after the clear, so a simultaneous set wins.
         int_stat <= (int_stat & ~istat_clr) | (sta_in & ~status);
         if (wr_commit && hit_ctrl)
            ctrl <= (ctrl & ~m32) | (pwdata[31:0] & m32);
         if (wr_commit && hit_ien)
            int_en <= (int_en & ~m32[STA_W-1:0]) | (pwdata[STA_W-1:0] & m32[STA_W-1:0]);
         if ((state == ACK) && pslverr && (err_cnt != 16'hFFFF))
            err_cnt <= err_cnt + 16'd1;
         irq <= |(int_stat & int_en);
      end
   end

   assign ctrl_ena = ctrl[0];
   assign ctrl_cfg = ctrl[31:1];

endmodule

// File: tb/tb_apb_ral_apb_mem_v2.sv
// Self-checking bench for apb_ral_apb_mem_v2: directed register/RAM scenarios plus
// randomized traffic against an array-based reference model.
module tb_apb_ral_apb_mem_v2;

   localparam int          WS    = 3;
   localparam int          STA_W = 8;
   localparam logic [15:0] RB    = 16'h1000;

   logic        pclk;
   logic        presetn;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [15:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic [7:0]  sta_in;
   logic        ctrl_ena;
   logic [30:0] ctrl_cfg;
   logic        irq;

   int assertCount = 0;
   int failCount   = 0;

   logic [31:0] memModel [0:1023];
   logic [31:0] ctrlModel;
   logic [7:0]  staModel;
   logic [7:0]  intStatModel;
   logic [7:0]  intEnModel;
   int          errCntModel;

   apb_ral_apb_mem_v2 #(
      .ADDR_W(16), .DATA_W(32), .RAM_WORDS(1024), .REG_BASE('h1000),
      .WAIT_STATES(WS), .STA_W(STA_W)
   ) dut (
      .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata), .pready(pready), .pslverr(pslverr), .sta_in(sta_in),
      .ctrl_ena(ctrl_ena), .ctrl_cfg(ctrl_cfg), .irq(irq)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Reference model: byte merge, address map and register semantics as plain arithmetic.
   function automatic logic [31:0] merge(input logic [31:0] oldV, input logic [31:0] newV,
                                         input logic [3:0] strb);
      logic [31:0] r = oldV;
      for (int b = 0; b < 4; b++)
         if (strb[b]) r[8*b +: 8] = newV[8*b +: 8];
      return r;
   endfunction

   function automatic bit isMapped(input logic [15:0] a);
      if (a % 4 != 0) return 1'b0;
      if (a < 16'h1000) return 1'b1;
      return (a >= RB) && (a <= RB + 16'h10);
   endfunction

   function automatic logic [31:0] modelRead(input logic [15:0] a);
      if (!isMapped(a)) return 32'h0BADCAFE;
      if (a < 16'h1000) return memModel[a / 4];
      case (int'(a - RB))
         0:       return ctrlModel;
         4:       return {24'h0, staModel};
         8:       return {24'h0, intStatModel};
         12:      return {24'h0, intEnModel};
         default: return 32'(errCntModel);
      endcase
   endfunction

   task automatic modelWrite(input logic [15:0] a, input logic [31:0] d, input logic [3:0] strb);
      logic [31:0] m;
      m = merge(32'h0, 32'hFFFF_FFFF, strb);
      if (a < 16'h1000)
         memModel[a / 4] = merge(memModel[a / 4], d, strb);
      else case (int'(a - RB))
         0:  ctrlModel = merge(ctrlModel, d, strb);
         8:  intStatModel = intStatModel & ~(d[7:0] & m[7:0]);
         12: intEnModel = merge({24'h0, intEnModel}, d, strb) & 8'hFF;
         default: ;
      endcase
   endtask

   task automatic staModelUpdate(input logic [7:0] v);
      intStatModel = intStatModel | (v & ~staModel);
      staModel     = v;
   endtask

   task automatic setSta(input logic [7:0] v);
      sta_in = v;
      staModelUpdate(v);
   endtask

   task automatic modelReset();
      ctrlModel    = '0;
      staModel     = '0;
      intStatModel = '0;
      intEnModel   = '0;
      errCntModel  = 0;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge pclk);
         #1;
      end
   endtask

   // One APB transfer: setup, access with wait-state count, optional sta_in change in ACK.
   task automatic applyStimulus(input bit wr, input logic [15:0] a, input logic [31:0] d,
                                input logic [3:0] strb, input bit staAtAck,
                                input logic [7:0] staVal, output logic [31:0] rd,
                                output logic err, output int waits);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = strb;
      tick(1);
      penable = 1'b1;
      waits = 0;
      while (pready !== 1'b1 && waits < 20) begin
         waits++;
         tick(1);
      end
      if (waits >= 20) checkOutput("pready_timeout", {63'h0, pready}, 64'h1);
      rd  = prdata;
      err = pslverr;
      if (staAtAck) sta_in = staVal;
      tick(1);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic runXfer(input string tag, input bit wr, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] strb,
                          input bit staAtAck, input logic [7:0] staVal);
      logic [31:0] expData, obsData;
      logic        expErr, obsErr;
      int          waits;
      expErr  = !isMapped(a);
      expData = modelRead(a);
      if (expErr) begin
         if (errCntModel < 65535) errCntModel++;
      end else if (wr) begin
         modelWrite(a, d, strb);
      end
      applyStimulus(wr, a, d, strb, staAtAck, staVal, obsData, obsErr, waits);
      if (staAtAck) staModelUpdate(staVal);
      checkOutput({tag, "_waits"}, 64'(waits), 64'(WS));
      checkOutput({tag, "_pslverr"}, {63'h0, obsErr}, {63'h0, expErr});
      if (!wr || expErr) checkOutput({tag, "_prdata"}, {32'h0, obsData}, {32'h0, expData});
   endtask

   initial begin
      logic [15:0] a;
      logic [31:0] d;
      int          kind;

      presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0; sta_in = '0;
      modelReset();
      tick(2);
      checkOutput("rst_prdata", {32'h0, prdata}, 64'h0);
      checkOutput("rst_pready", {63'h0, pready}, 64'h0);
      checkOutput("rst_pslverr", {63'h0, pslverr}, 64'h0);
      checkOutput("rst_irq", {63'h0, irq}, 64'h0);
      checkOutput("rst_ctrl_ena", {63'h0, ctrl_ena}, 64'h0);
      checkOutput("rst_ctrl_cfg", {33'h0, ctrl_cfg}, 64'h0);
      presetn = 1'b1;
      tick(1);

      $display("[TB] RAM write/read with wait states");
      runXfer("t1_wr", 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b0, 8'h0);
      runXfer("t1_rd", 1'b0, 16'h0010, 32'h0, 4'hF, 1'b0, 8'h0);

      $display("[TB] CTRL byte strobe");
      runXfer("t2_wr", 1'b1, RB, 32'hFFFF_FFFF, 4'b0001, 1'b0, 8'h0);
      runXfer("t2_rd", 1'b0, RB, 32'h0, 4'hF, 1'b0, 8'h0);
      checkOutput("t2_ena", {63'h0, ctrl_ena}, {63'h0, ctrlModel[0]});
      checkOutput("t2_cfg", {33'h0, ctrl_cfg}, {33'h0, ctrlModel[31:1]});

      $display("[TB] interrupts and W1C");
      runXfer("t3_ien", 1'b1, RB + 16'h0C, 32'h04, 4'hF, 1'b0, 8'h0);
      setSta(8'h05);
      tick(1);
      checkOutput("t3_irq_early", {63'h0, irq}, 64'h0);
      tick(1);
      checkOutput("t3_irq_set", {63'h0, irq}, 64'h1);
      runXfer("t3_rd_ist", 1'b0, RB + 16'h08, 32'h0, 4'hF, 1'b0, 8'h0);
      runXfer("t3_w1c", 1'b1, RB + 16'h08, 32'h04, 4'hF, 1'b0, 8'h0);
      tick(1);
      checkOutput("t3_irq_clr", {63'h0, irq}, 64'h0);
      runXfer("t3_rd_ist2", 1'b0, RB + 16'h08, 32'h0, 4'hF, 1'b0, 8'h0);
      setSta(8'h01);
      tick(2);
      runXfer("t3_w1c_race", 1'b1, RB + 16'h08, 32'h04, 4'hF, 1'b1, 8'h05);
      runXfer("t3_rd_race", 1'b0, RB + 16'h08, 32'h0, 4'hF, 1'b0, 8'h0);
      tick(1);
      checkOutput("t3_irq_race", {63'h0, irq}, 64'h1);

      $display("[TB] unmapped and misaligned accesses");
      runXfer("t4_ram0", 1'b1, 16'h0000, 32'h1234_5678, 4'hF, 1'b0, 8'h0);
      runXfer("t4_rd_unm", 1'b0, RB + 16'h20, 32'h0, 4'hF, 1'b0, 8'h0);
      runXfer("t4_wr_mis", 1'b1, 16'h0003, 32'hAAAA_AAAA, 4'hF, 1'b0, 8'h0);
      runXfer("t4_ecnt", 1'b0, RB + 16'h10, 32'h0, 4'hF, 1'b0, 8'h0);
      runXfer("t4_ram0_rd", 1'b0, 16'h0000, 32'h0, 4'hF, 1'b0, 8'h0);

      $display("[TB] STATUS is read-only");
      setSta(8'h3C);
      tick(1);
      runXfer("t5_wr_sta", 1'b1, RB + 16'h04, 32'hFF, 4'hF, 1'b0, 8'h0);
      runXfer("t5_rd_sta", 1'b0, RB + 16'h04, 32'h0, 4'hF, 1'b0, 8'h0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 32; i++)
         runXfer("rnd_init", 1'b1, 16'(4 * i), $urandom, 4'hF, 1'b0, 8'h0);
      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 9);
         d    = $urandom;
         if (kind <= 5) begin
            a = 16'(4 * $urandom_range(0, 31));
            runXfer("rnd_ram", kind[0], a, d, 4'($urandom_range(0, 15)), 1'b0, 8'h0);
         end else if (kind == 6) begin
            runXfer("rnd_ctrl_wr", 1'b1, RB, d, 4'($urandom_range(0, 15)), 1'b0, 8'h0);
            checkOutput("rnd_ctrl_ena", {63'h0, ctrl_ena}, {63'h0, ctrlModel[0]});
            checkOutput("rnd_ctrl_cfg", {33'h0, ctrl_cfg}, {33'h0, ctrlModel[31:1]});
         end else if (kind == 7) begin
            runXfer("rnd_ctrl_rd", 1'b0, RB, d, 4'hF, 1'b0, 8'h0);
         end else if (kind == 8) begin
            if (d[0]) a = 16'(4 * $urandom_range(0, 31) + $urandom_range(1, 3));
            else      a = RB + 16'(4 * $urandom_range(5, 20));
            runXfer("rnd_err", d[1], a, $urandom, 4'hF, 1'b0, 8'h0);
         end else begin
            runXfer("rnd_ecnt", 1'b0, RB + 16'h10, d, 4'hF, 1'b0, 8'h0);
         end
      end
      runXfer("rnd_ram_final", 1'b0, 16'h0010, 32'h0, 4'hF, 1'b0, 8'h0);

      $display("[TB] reset during WAIT");
      setSta(8'h00);
      tick(2);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = RB; pwdata = 32'h1; pstrb = 4'hF;
      tick(1);
      penable = 1'b1;
      tick(1);
      presetn = 1'b0;
      #1;
      checkOutput("t6_pready_in_rst", {63'h0, pready}, 64'h0);
      tick(2);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      presetn = 1'b1;
      modelReset();
      tick(1);
      checkOutput("t6_pready_after", {63'h0, pready}, 64'h0);
      checkOutput("t6_ctrl_ena", {63'h0, ctrl_ena}, 64'h0);
      runXfer("t6_rd_ctrl", 1'b0, RB, 32'h0, 4'hF, 1'b0, 8'h0);
      runXfer("t6_ram_kept", 1'b0, 16'h0010, 32'h0, 4'hF, 1'b0, 8'h0);
      runXfer("t6_wr_ctrl", 1'b1, RB, 32'h1, 4'hF, 1'b0, 8'h0);
      runXfer("t6_rd_ctrl2", 1'b0, RB, 32'h0, 4'hF, 1'b0, 8'h0);
      checkOutput("t6_ena", {63'h0, ctrl_ena}, 64'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/apb_ral_apb_mem_v2.md
Name: apb_ral_apb_mem_v2

Overview:
Parametrised APB3/APB4 completer that combines a word-addressed RAM window with a small RAL-visible register bank. It is the RAL bench target for the APB agent and replaces the fixed 4 KB, zero-wait, error-free memory model. It adds:
- configurable data width, RAM depth and register base;
- programmable wait states and byte strobes;
- PSLVERR on unmapped addresses;
- RW, RO and W1C register types, with an interrupt output.

Parameters:
- ADDR_W, 16, paddr width.
- DATA_W, 32, pwdata/prdata width; legal values 32 or 64.
- RAM_WORDS, 1024, RAM depth in DATA_W words; RAM occupies 0 .. RAM_WORDS*(DATA_W/8)-1.
- REG_BASE, 'h1000, byte address of register bank; must be ≥ RAM end.
- WAIT_STATES, 0, pready-low cycles inserted in every access phase (0..15).
- STA_W, 8, width of hardware status input.

Ports:
- pclk  in  1  APB clock.
- presetn  in  1  Asynchronous reset, active low.
- psel  in  1  Completer select.
- penable  in  1  Access phase.
- pwrite  in  1  1 = write.
- paddr  in  ADDR_W  Byte address.
- pwdata  in  DATA_W  Write data.
- pstrb  in  DATA_W/8  Byte strobes; tie all-ones for APB3.
- prdata  out  DATA_W  Read data.
- pready  out  1  Transfer complete.
- pslverr  out  1  Error response, valid with pready.
- sta_in  in  STA_W  Hardware status, synchronous to pclk.
- ctrl_ena  out  1  CTRL[0].
- ctrl_cfg  out  31  CTRL[31:1].
- irq  out  1  Registered interrupt.

Behaviour:
- One clock (pclk). presetn is asynchronous and active low.
- Reset values: prdata=0, pready=0, pslverr=0, irq=0, ctrl_ena=0, ctrl_cfg=0, all registers 0, FSM=IDLE. RAM contents are not reset and are retained across reset.
- Register map (offset from REG_BASE; 32-bit registers zero-extended to DATA_W; upper strobes ignored):
  - 0x00 CTRL, RW: [0] ena, [31:1] cfg.
  - 0x04 STATUS, RO: sta_in registered once per cycle; writes ignored with no error.
  - 0x08 INT_STAT, W1C: bit i sets on a rising edge of STATUS[i]. If a hardware set and a W1C clear hit the same bit in the same cycle, set wins.
  - 0x0C INT_EN, RW: [STA_W-1:0]; upper bits read 0.
  - 0x10 ERR_CNT, RO: 16-bit count of pslverr responses; saturates at 'hFFFF; writes ignored.
- Unmapped address: any address not in the RAM range and not one of the 5 register offsets, or any address that is not DATA_W-aligned. Response is pslverr=1, prdata='h0BADCAFE zero-extended, no state change apart from ERR_CNT.
- FSM states IDLE, WAIT, ACK:
  - IDLE→WAIT on psel & !penable (setup phase); load wait counter with WAIT_STATES.
  - WAIT: pready=0; decrement each cycle with penable=1. At 0 go to ACK. With WAIT_STATES=0, ACK is entered directly from the setup phase.
  - ACK: pready=1 for exactly one cycle. prdata and pslverr are valid in this cycle, then return to IDLE.
  - pready is driven only from ACK; pslverr is 0 outside ACK.
  - psel dropping in WAIT/ACK (protocol violation) forces IDLE with no write commit.
- Writes commit on the ACK cycle only, with per-byte pstrb masking on RAM and CTRL/INT_EN.
- Reads sample address and data in the cycle before ACK, so prdata is registered. Reading INT_STAT has no side effect.
- Back-to-back transfers: a new setup phase may follow ACK immediately. Minimum transfer is 2 cycles at WAIT_STATES=0.
- irq = |(INT_STAT & INT_EN), registered, so 1-cycle latency after INT_STAT/INT_EN update.
- Reset asserted mid-transfer: FSM goes to IDLE immediately and the pending write is dropped.

Test Plan:
1. WAIT_STATES=3: write RAM 0x0010 = 'hDEADBEEF, then read it back → pready low for 3 cycles of each access phase, read returns 'hDEADBEEF, pslverr=0.
2. Write CTRL = 'hFFFFFFFF with pstrb='b0001 from a zeroed CTRL → CTRL reads 'h000000FF, ctrl_ena=1, ctrl_cfg='h7F.
3. Drive sta_in 0→'h05, set INT_EN='h04 → INT_STAT='h05, irq=1 two cycles after the edge. W1C 'h04 → INT_STAT='h01, irq=0. Repeat with an sta_in edge on bit 2 in the same cycle as the W1C → bit 2 stays set.
4. Read REG_BASE+0x20, then write 0x0003 (misaligned) → both give pslverr=1, the read returns 'h0BADCAFE, ERR_CNT=2, RAM unchanged.
5. Write STATUS = 'hFF with sta_in='h3C → no error, STATUS reads 'h3C.
6. Assert presetn during the WAIT state of a CTRL write of 'h1 → after reset CTRL=0 and pready=0. The next transfer completes normally.
